// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the execute-stage ALU issue block:
// ALU op codes, RV32I opcode/funct fields, FSM states and the decode bundle.
package alu_issue_pkg;
  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;
  localparam logic [3:0] ALU_NE   = 4'd11;
  localparam logic [3:0] ALU_GE   = 4'd12;
  localparam logic [3:0] ALU_GEU  = 4'd13;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CAPTURE, S_DONE} state_t;
  typedef enum logic [1:0] {X_RS1, X_PC, X_ZERO} xsel_t;
  typedef enum logic {Y_RS2, Y_IMM} ysel_t;

  typedef struct packed {
    logic [3:0]  aluOp;
    xsel_t       xSel;
    ysel_t       ySel;
    logic [31:0] imm;
    logic [31:0] bImm;
    logic        isBranch;
    logic        illegal;
  } dec_t;

  // Register/immediate arithmetic op from funct3; alt picks SUB/SRA.
  function automatic logic [3:0] arithOp(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  arithOp = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  arithOp = ALU_SLL;
      F3_SLT:  arithOp = ALU_SLT;
      F3_SLTU: arithOp = ALU_SLTU;
      F3_XOR:  arithOp = ALU_XOR;
      F3_SR:   arithOp = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   arithOp = ALU_OR;
      default: arithOp = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decode of OP/OP-IMM/LUI/AUIPC/BRANCH into ALU op,
// operand selects, immediate, branch flag and illegal flag.
module alu_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);
  logic [2:0] f3;
  logic [6:0] f7;
  logic       bad;
  logic       unusedRs1;

  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign unusedRs1 = ^instr[19:15];

  always_comb begin
    bad          = 1'b0;
    dec.aluOp    = ALU_ADD;
    dec.xSel     = X_RS1;
    dec.ySel     = Y_RS2;
    dec.imm      = '0;
    dec.bImm     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    dec.isBranch = 1'b0;
    dec.illegal  = 1'b0;
    case (instr[6:0])
      OPCODE_OP: begin
        if (f7 == F7_BASE) dec.aluOp = arithOp(f3, 1'b0);
        else if (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)) dec.aluOp = arithOp(f3, 1'b1);
        else bad = 1'b1;
      end
      OPCODE_OPIMM: begin
        dec.ySel = Y_IMM;
        dec.imm  = {{20{instr[31]}}, instr[31:20]};
        case (f3)
          F3_SLL: begin
            dec.imm   = {27'b0, instr[24:20]};
            dec.aluOp = ALU_SLL;
            bad       = (f7 != F7_BASE);
          end
          F3_SR: begin
            dec.imm   = {27'b0, instr[24:20]};
            dec.aluOp = instr[30] ? ALU_SRA : ALU_SRL;
            bad       = (f7 != F7_BASE) && (f7 != F7_ALT);
          end
          default: dec.aluOp = arithOp(f3, 1'b0);
        endcase
      end
      OPCODE_LUI: begin
        dec.xSel = X_ZERO;
        dec.ySel = Y_IMM;
        dec.imm  = {instr[31:12], 12'b0};
      end
      OPCODE_AUIPC: begin
        dec.xSel = X_PC;
        dec.ySel = Y_IMM;
        dec.imm  = {instr[31:12], 12'b0};
      end
      OPCODE_BRANCH: begin
        dec.isBranch = 1'b1;
        case (f3)
          F3_BEQ:  dec.aluOp = ALU_EQ;
          F3_BNE:  dec.aluOp = ALU_NE;
          F3_BLT:  dec.aluOp = ALU_SLT;
          F3_BGE:  dec.aluOp = ALU_GE;
          F3_BLTU: dec.aluOp = ALU_SLTU;
          F3_BGEU: dec.aluOp = ALU_GEU;
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    // Illegal encodings still run through the ALU as 0+0 so latency is uniform.
    if (bad) begin
      dec.aluOp    = ALU_ADD;
      dec.xSel     = X_ZERO;
      dec.ySel     = Y_IMM;
      dec.imm      = '0;
      dec.isBranch = 1'b0;
      dec.illegal  = 1'b1;
    end
  end
endmodule

// File: rtl/alu_issue.sv
// Execute-stage initiator: decodes into the registered ALU, waits its one-cycle
// latency, captures the result and holds it on a valid/ready port.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1Data,
  input  logic [31:0] rs2Data,
  input  logic [31:0] pc,
  output logic [3:0]  aluOp,
  output logic [31:0] aluX,
  output logic [31:0] aluY,
  input  logic [31:0] aluO,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  rdAddr,
  output logic        rdWrite,
  output logic [31:0] rdResult,
  output logic        branchTaken,
  output logic [31:0] branchTarget,
  output logic        illegal
);
  state_t      state, nextState;
  dec_t        dec;
  logic        isBranch;
  logic        accept;
  logic [31:0] xNext, yNext;

  alu_decode uDecode (.instr(instr), .dec(dec));

  always_comb begin
    case (dec.xSel)
      X_PC:    xNext = pc;
      X_ZERO:  xNext = '0;
      default: xNext = rs1Data;
    endcase
    yNext = (dec.ySel == Y_IMM) ? dec.imm : rs2Data;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nextState = S_EXEC;
      end
      S_EXEC:    nextState = S_CAPTURE;
      S_CAPTURE: nextState = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) nextState = S_IDLE;
      end
      default: nextState = S_IDLE;
    endcase
  end

  assign accept = (state == S_IDLE) && in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      aluOp        <= ALU_ADD;
      aluX         <= '0;
      aluY         <= '0;
      rdAddr       <= '0;
      branchTarget <= '0;
      isBranch     <= 1'b0;
      illegal      <= 1'b0;
      rdResult     <= '0;
      branchTaken  <= 1'b0;
      rdWrite      <= 1'b0;
    end else if (accept) begin
      aluOp        <= dec.aluOp;
      aluX         <= xNext;
      aluY         <= yNext;
      rdAddr       <= instr[11:7];
      branchTarget <= pc + dec.bImm;
      isBranch     <= dec.isBranch;
      illegal      <= dec.illegal;
    end else if (state == S_CAPTURE) begin
      // aluO reflects the operands sampled by the ALU on the EXEC->CAPTURE edge.
      rdResult    <= aluO;
      branchTaken <= aluO[0] & isBranch;
      rdWrite     <= !isBranch && !illegal && (rdAddr != 5'd0);
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural registered ALU attached.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, rs1Data, rs2Data, pc;
  logic [3:0]  aluOp;
  logic [31:0] aluX, aluY, aluO;
  logic [4:0]  rdAddr;
  logic        rdWrite, branchTaken, illegal;
  logic [31:0] rdResult, branchTarget;
  int          nChecks = 0;
  int          nFail = 0;
  int          lat;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1Data(rs1Data), .rs2Data(rs2Data), .pc(pc),
    .aluOp(aluOp), .aluX(aluX), .aluY(aluY), .aluO(aluO),
    .out_valid(out_valid), .out_ready(out_ready), .rdAddr(rdAddr),
    .rdWrite(rdWrite), .rdResult(rdResult), .branchTaken(branchTaken),
    .branchTarget(branchTarget), .illegal(illegal)
  );

  // External ALU: result registered one cycle after operands.
  always @(posedge clk) begin
    case (aluOp)
      ALU_ADD:  aluO <= aluX + aluY;
      ALU_SUB:  aluO <= aluX - aluY;
      ALU_SLL:  aluO <= aluX << aluY[4:0];
      ALU_SLT:  aluO <= {31'b0, $signed(aluX) < $signed(aluY)};
      ALU_SLTU: aluO <= {31'b0, aluX < aluY};
      ALU_XOR:  aluO <= aluX ^ aluY;
      ALU_SRL:  aluO <= aluX >> aluY[4:0];
      ALU_SRA:  aluO <= $signed(aluX) >>> aluY[4:0];
      ALU_OR:   aluO <= aluX | aluY;
      ALU_AND:  aluO <= aluX & aluY;
      ALU_EQ:   aluO <= {31'b0, aluX == aluY};
      ALU_NE:   aluO <= {31'b0, aluX != aluY};
      ALU_GE:   aluO <= {31'b0, $signed(aluX) >= $signed(aluY)};
      ALU_GEU:  aluO <= {31'b0, aluX >= aluY};
      default:  aluO <= 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one instruction; lat counts edges from the accept edge to out_valid.
  task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, output int l);
    @(negedge clk);
    instr = i; rs1Data = a; rs2Data = b; pc = p; in_valid = 1'b1;
    @(posedge clk); l = 1;
    #1 in_valid = 1'b0;
    while (!out_valid && l < 10) begin
      @(posedge clk); #1; l++;
    end
  endtask

  task automatic release_out();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    check("in_ready_after_hs", {31'b0, in_ready}, 32'd1);
    check("out_valid_after_hs", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; rs1Data = '0; rs2Data = '0; pc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready}, 32'd1);
    check("rst_aluOp",     {28'b0, aluOp}, {28'b0, ALU_ADD});
    check("rst_aluX",      aluX, 32'd0);
    check("rst_rdResult",  rdResult, 32'd0);
    check("rst_branchTarget", branchTarget, 32'd0);
    rst = 1'b0;

    // ADD x3,x1,x2
    issue(32'h002081B3, 32'd5, 32'd7, 32'h0, lat);
    check("add_latency", lat, 32'd3);
    check("add_rdAddr", {27'b0, rdAddr}, 32'd3);
    check("add_rdResult", rdResult, 32'd12);
    check("add_rdWrite", {31'b0, rdWrite}, 32'd1);
    check("add_branchTaken", {31'b0, branchTaken}, 32'd0);
    check("add_illegal", {31'b0, illegal}, 32'd0);
    release_out();

    issue(32'h402081B3, 32'd5, 32'd7, 32'h0, lat);
    check("sub_rdResult", rdResult, 32'hFFFF_FFFE);
    release_out();

    issue(32'h40435293, 32'h8000_0000, 32'd0, 32'h0, lat);
    check("srai_rdResult", rdResult, 32'hF800_0000);
    check("srai_rdAddr", {27'b0, rdAddr}, 32'd5);
    release_out();

    // BLT taken, BLTU not taken, same operands
    issue(32'h0020C463, 32'hFFFF_FFFF, 32'd1, 32'h100, lat);
    check("blt_taken", {31'b0, branchTaken}, 32'd1);
    check("blt_target", branchTarget, 32'h108);
    check("blt_rdWrite", {31'b0, rdWrite}, 32'd0);
    release_out();

    issue(32'h0020E463, 32'hFFFF_FFFF, 32'd1, 32'h100, lat);
    check("bltu_taken", {31'b0, branchTaken}, 32'd0);
    check("bltu_target", branchTarget, 32'h108);
    release_out();

    issue(32'h123453B7, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0, lat);
    check("lui_rdResult", rdResult, 32'h1234_5000);
    check("lui_rdAddr", {27'b0, rdAddr}, 32'd7);
    release_out();

    // AUIPC x1,1 at pc 0x100
    issue(32'h00001097, 32'd0, 32'd0, 32'h100, lat);
    check("auipc_rdResult", rdResult, 32'h0000_1100);
    release_out();

    issue(32'h00208033, 32'd5, 32'd7, 32'h0, lat);
    check("add_x0_rdWrite", {31'b0, rdWrite}, 32'd0);
    check("add_x0_rdResult", rdResult, 32'd12);
    release_out();

    // Backpressure: hold out_ready low while offering another instruction
    issue(32'h002081B3, 32'd20, 32'd22, 32'h0, lat);
    @(negedge clk);
    instr = 32'h402081B3; rs1Data = 32'd1; rs2Data = 32'd1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_rdResult", rdResult, 32'd42);
      check("bp_rdAddr", {27'b0, rdAddr}, 32'd3);
    end
    in_valid = 1'b0;
    release_out();
    repeat (3) @(posedge clk);
    #1 check("bp_no_ghost", {31'b0, out_valid}, 32'd0);

    // Unknown opcode and reserved funct7 form
    issue(32'h0000007F, 32'd9, 32'd9, 32'h0, lat);
    check("illop_latency", lat, 32'd3);
    check("illop_illegal", {31'b0, illegal}, 32'd1);
    check("illop_rdWrite", {31'b0, rdWrite}, 32'd0);
    check("illop_branchTaken", {31'b0, branchTaken}, 32'd0);
    release_out();

    issue(32'h4020E1B3, 32'd3, 32'd4, 32'h0, lat);
    check("illf7_illegal", {31'b0, illegal}, 32'd1);
    check("illf7_rdWrite", {31'b0, rdWrite}, 32'd0);
    release_out();

    // Reset while in EXEC
    @(negedge clk);
    instr = 32'h002081B3; rs1Data = 32'd1; rs2Data = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_in_ready", {31'b0, in_ready}, 32'd1);
    check("rstmid_out_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rstmid_no_output", {31'b0, out_valid}, 32'd0);
    check("rstmid_rdResult", rdResult, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
